// File: rtl/pc_fetch_unit_if.sv
// Handshake bundle between the fetch unit, instruction memory and decode.
// master: the fetch unit side; slave: the memory/decode environment side.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per PC over a
// req/ack memory handshake and holds it for decode over valid/ready.
// Optional fetch timeout with redirect to SYSCALL_VEC: macro PC_FETCH_TIMEOUT_EN.
module pc_fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] SYSCALL_VEC = 16'hFF00,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   halt,
  input  logic [15:0]            nextaddr,
  output logic [15:0]            pc,
  output logic [15:0]            link_addr,
  output logic                   fetch_err,
  pc_fetch_unit_if.master        bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;

`ifdef PC_FETCH_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`else
  // Keeps the timeout-only parameters referenced in the build without a counter.
  logic unused_cfg;
  assign unused_cfg = ^{SYSCALL_VEC, 8'(TIMEOUT)};
`endif

  // Next-state and datapath: REQ captures on ack, HOLD advances PC on ready.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef PC_FETCH_TIMEOUT_EN
    cnt_d   = 8'd0;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!halt) state_d = S_REQ;
      end
      S_REQ: begin
        // An ack on the cycle the count expires wins over the timeout.
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          state_d = S_HOLD;
        end
`ifdef PC_FETCH_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_CNT - 8'd1) begin
          pc_d    = SYSCALL_VEC;
          err_d   = 1'b1;
          state_d = halt ? S_IDLE : S_REQ;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_HOLD: begin
        if (bus.instr_ready) begin
          pc_d    = nextaddr;
          state_d = halt ? S_IDLE : S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, PC and instruction registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
    end else begin
      // NOTE: non-blocking assignments so all flops sample pre-edge values together.
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

`ifdef PC_FETCH_TIMEOUT_EN
  // Timeout counter and one-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  // Outputs decoded from state so req/valid fall as soon as reset asserts.
  assign bus.imem_req    = (state_q == S_REQ);
  assign bus.instr_valid = (state_q == S_HOLD);
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign pc              = pc_q;
  assign link_addr       = pc_q + 16'd1;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: fetched words are pushed to a
// scoreboard when acked and popped when decode accepts them.
module tb_pc_fetch_unit;
  localparam logic [15:0] RST_PC = 16'h0000;
  localparam logic [15:0] SYS_PC = 16'hFF00;

  logic        clk;
  logic        rst_n;
  logic        halt;
  logic [15:0] nextaddr;
  logic [15:0] pc;
  logic [15:0] link_addr;
  logic        fetch_err;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_PC    (RST_PC),
    .SYSCALL_VEC (SYS_PC),
    .TIMEOUT     (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .halt      (halt),
    .nextaddr  (nextaddr),
    .pc        (pc),
    .link_addr (link_addr),
    .fetch_err (fetch_err),
    .bus       (bus.master)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // In REQ: hold off the ack for wait_cycles, then ack with rdata.
  task automatic fetch(input logic [15:0] rdata, input logic [15:0] exp_addr, input int wait_cycles);
    check("req_before_ack", bus.imem_req, 1'b1);
    check("addr_before_ack", bus.imem_addr, exp_addr);
    for (int i = 0; i < wait_cycles; i++) begin
      tick();
      check("req_held", bus.imem_req, 1'b1);
      check("addr_held", bus.imem_addr, exp_addr);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = rdata;
    exp_q.push_back(rdata);
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0000;
    check("valid_after_ack", bus.instr_valid, 1'b1);
    check("req_after_ack", bus.imem_req, 1'b0);
    check("err_after_ack", fetch_err, 1'b0);
  endtask

  // In HOLD: stall for ready_delay cycles, then accept with nextaddr = nxt.
  task automatic accept(input logic [15:0] nxt, input int ready_delay, input logic halt_v);
    logic [15:0] pc_hold;
    logic [15:0] exp_instr;
    pc_hold = pc;
    for (int i = 0; i < ready_delay; i++) begin
      tick();
      check("bp_valid", bus.instr_valid, 1'b1);
      check("bp_req", bus.imem_req, 1'b0);
      check("bp_pc", pc, pc_hold);
    end
    if (exp_q.size() == 0) begin
      check("sb_empty_pop", 16'h0001, 16'h0000);
    end else begin
      exp_instr = exp_q.pop_front();
      check("sb_instr", bus.instr, exp_instr);
    end
    bus.instr_ready = 1'b1;
    nextaddr        = nxt;
    halt            = halt_v;
    tick();
    bus.instr_ready = 1'b0;
    check("pc_advance", pc, nxt);
    check("addr_advance", bus.imem_addr, nxt);
    check("link_advance", link_addr, nxt + 16'd1);
    check("valid_cleared", bus.instr_valid, 1'b0);
    check("req_after_accept", bus.imem_req, !halt_v);
  endtask

  initial begin
    rst_n           = 1'b1;
    halt            = 1'b0;
    nextaddr        = 16'h0000;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 16'h0000;
    bus.instr_ready = 1'b0;

    // Reset state.
    #1 rst_n = 1'b0;
    #1;
    check("rst_pc", pc, RST_PC);
    check("rst_req", bus.imem_req, 1'b0);
    check("rst_valid", bus.instr_valid, 1'b0);
    check("rst_instr", bus.instr, 16'h0000);
    check("rst_err", fetch_err, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // First edge after reset enters REQ.
    tick();
    check("first_req", bus.imem_req, 1'b1);
    check("first_link", link_addr, 16'h0001);

    // Zero-wait fetch and advance.
    fetch(16'h1234, 16'h0000, 0);
    accept(16'h0042, 0, 1'b0);

    // Slow memory plus 5 cycles of decode backpressure, then wrap to FFFF.
    fetch(16'hABCD, 16'h0042, 2);
    accept(16'hFFFF, 5, 1'b0);
    check("link_wrap", link_addr, 16'h0000);

    // Halt during the handshake parks the unit in IDLE.
    fetch(16'h5555, 16'hFFFF, 0);
    accept(16'h0010, 0, 1'b1);
    tick();
    check("idle_req", bus.imem_req, 1'b0);
    bus.instr_ready = 1'b1;
    nextaddr        = 16'h7777;
    tick();
    bus.instr_ready = 1'b0;
    check("ready_when_invalid", pc, 16'h0010);
    halt = 1'b0;
    tick();
    check("unhalt_req", bus.imem_req, 1'b1);

    // Ack outside REQ must not disturb the held word.
    fetch(16'h7777, 16'h0010, 1);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'hDEAD;
    tick();
    bus.imem_ack   = 1'b0;
    check("ack_in_hold", bus.instr, 16'h7777);
    accept(16'h0020, 0, 1'b0);

`ifdef PC_FETCH_TIMEOUT_EN
    // Three REQ cycles without ack redirect to the syscall vector.
    tick();
    check("to_err_1", fetch_err, 1'b0);
    tick();
    check("to_err_2", fetch_err, 1'b0);
    tick();
    check("to_err_pulse", fetch_err, 1'b1);
    check("to_pc", pc, SYS_PC);
    check("to_addr", bus.imem_addr, SYS_PC);
    check("to_req", bus.imem_req, 1'b1);
    check("to_valid", bus.instr_valid, 1'b0);
    // Ack in the very cycle the count expires wins.
    fetch(16'h9999, SYS_PC, 2);
    check("to_err_dropped", fetch_err, 1'b0);
    accept(16'h0030, 0, 1'b0);
`else
    // Without the timeout the request is held indefinitely.
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_err", fetch_err, 1'b0);
    end
    fetch(16'h9999, 16'h0020, 0);
    accept(16'h0030, 0, 1'b0);
`endif

    // Reset asserted mid-REQ clears outputs without a clock edge.
    check("pre_rst_req", bus.imem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req", bus.imem_req, 1'b0);
    check("mid_rst_pc", pc, RST_PC);
    check("mid_rst_valid", bus.instr_valid, 1'b0);
    #1 rst_n = 1'b1;
    tick();
    fetch(16'h0BAD, RST_PC, 0);
    accept(16'h0001, 0, 1'b0);
    check("sb_drained", 16'(exp_q.size()), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
